// File: rtl/channel_balancer_pkg.sv
// Shared helpers for the channel family: lane-index sizing and saturating
// latency arithmetic.
package channel_balancer_pkg;

    // Widest latency estimate the helpers below can carry.
    localparam int LAT_MAX_WIDTH = 32;

    // Width of a lane index; a single-lane build still gets a 1-bit index.
    function automatic int lane_idx_width(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    // a + b clamped to the all-ones value of a `width`-bit estimate.
    // Callers keep the low `width` bits of the result.
    function automatic logic [LAT_MAX_WIDTH-1:0] sat_add(
        input logic [LAT_MAX_WIDTH-1:0] a,
        input logic [LAT_MAX_WIDTH-1:0] b,
        input int                       width
    );
        logic [LAT_MAX_WIDTH:0] sum;
        logic [LAT_MAX_WIDTH:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = ({{LAT_MAX_WIDTH{1'b0}}, 1'b1} << width) - {{LAT_MAX_WIDTH{1'b0}}, 1'b1};
        if (sum >= lim) begin
            return lim[LAT_MAX_WIDTH-1:0];
        end
        return sum[LAT_MAX_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/lane_fifo.sv
// First-word-fall-through FIFO for one balancer lane: register-array storage,
// full decided from the registered count only.
module lane_fifo #(
    parameter int DWIDTH     = 10,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [DWIDTH-1:0]   din,
    input  logic                pop,
    output logic [DWIDTH-1:0]   dout,
    output logic                empty,
    output logic                full,
    output logic [DEPTH_LOG2:0] count
);

    localparam int                  DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] ONE_COUNT  = {{DEPTH_LOG2{1'b0}}, 1'b1};

    logic [DWIDTH-1:0]     mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_COUNT);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // NOTE: every variable is given its default first so no path through the
    // block leaves it unassigned, which would infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + ONE_COUNT;
            2'b01:   count_d = count_q - ONE_COUNT;
            default: count_d = count_q;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; a zero count already
    // marks every entry invalid, and leaving it unreset keeps it plain flops.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/channel_balancer.sv
// Spreads one input stream over LANES FIFO lanes, steering each item to the
// non-full lane with the lowest estimated wait (downstream latency + occupancy).
module channel_balancer
    import channel_balancer_pkg::*;
#(
    parameter int WIDTH               = 10,
    parameter int LANES               = 4,
    parameter int DEPTH_LOG2          = 4,
    parameter int LATENCY_COUNT_WIDTH = 10
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [WIDTH-1:0]                     in_data,
    output logic [LATENCY_COUNT_WIDTH-1:0]       in_latency,
    output logic [lane_idx_width(LANES)-1:0]     in_lane,
    output logic [LANES-1:0]                     out_valid,
    input  logic [LANES-1:0]                     out_ready,
    output logic [LANES*WIDTH-1:0]               out_data,
    input  logic [LANES*LATENCY_COUNT_WIDTH-1:0] out_latency
);

    localparam int LANE_W = lane_idx_width(LANES);
    localparam int LCW    = LATENCY_COUNT_WIDTH;

    logic [LANES-1:0]    lane_full;
    logic [LANES-1:0]    lane_empty;
    logic [LANES-1:0]    lane_push;
    logic [LANES-1:0]    lane_pop;
    logic [DEPTH_LOG2:0] lane_count [LANES];

    logic [LCW-1:0]      old_lat_q [LANES];
    logic [LCW-1:0]      old_lat_d [LANES];
    logic [LCW-1:0]      est [LANES];

    logic                sel_found;
    logic [LANE_W-1:0]   sel_idx;
    logic [LCW-1:0]      sel_est;
    logic [LANES-1:0]    sel_onehot;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        lane_fifo #(
            .DWIDTH     (WIDTH),
            .DEPTH_LOG2 (DEPTH_LOG2)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (lane_push[i]),
            .din   (in_data),
            .pop   (lane_pop[i]),
            .dout  (out_data[i*WIDTH +: WIDTH]),
            .empty (lane_empty[i]),
            .full  (lane_full[i]),
            .count (lane_count[i])
        );
    end

    assign out_valid = ~lane_empty;
    assign lane_pop  = out_ready & out_valid;

    // Downstream latency is registered one cycle, plus one for the hop itself.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            old_lat_d[i] = LCW'(sat_add(32'(out_latency[i*LCW +: LCW]), 32'd1, LCW));
            est[i]       = LCW'(sat_add(32'(old_lat_q[i]), 32'(lane_count[i]), LCW));
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (!rst) begin
                old_lat_q[i] <= LCW'(1);
            end else begin
                old_lat_q[i] <= old_lat_d[i];
            end
        end
    end

    // Linear argmin over non-full lanes; strict '<' keeps ties on the lowest index.
    always_comb begin
        sel_found  = 1'b0;
        sel_idx    = '0;
        sel_est    = '1;
        sel_onehot = '0;
        for (int i = 0; i < LANES; i++) begin
            if (!lane_full[i] && (!sel_found || (est[i] < sel_est))) begin
                sel_found  = 1'b1;
                sel_idx    = LANE_W'(i);
                sel_est    = est[i];
                sel_onehot = '0;
                sel_onehot[i] = 1'b1;
            end
        end
    end

    assign in_ready   = rst & sel_found;
    assign in_lane    = sel_idx;
    assign in_latency = sel_est;
    assign lane_push  = {LANES{in_valid & in_ready}} & sel_onehot;

endmodule
